// File: rtl/sram_sp_param.sv
// ---------------------------------------------------------------------------
// sram_sp_param : single-port synchronous SRAM with a registered, valid-strobed read port.
// Optional post-reset clear engine: define SRAM_SP_PARAM_INIT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_sp_param #(
   parameter int DATA_W  = 4,
   parameter int ADDR_W  = 5,
   parameter int WR_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              init_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int PTR_W = ADDR_W + 1;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
`ifdef SRAM_SP_PARAM_INIT_EN
   localparam logic [0:0] ST_RESET = ST_INIT;
`else
   localparam logic [0:0] ST_RESET = ST_RUN;
`endif

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [PTR_W-1:0]  ptr;
   logic              clear_we;
   logic              accept;
   logic [DATA_W-1:0] wr_dout;
   logic              wr_valid;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_RESET;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_INIT) begin
         if (ptr == PTR_W'(DEPTH - 1)) state_nxt = ST_RUN;
      end else begin
         state_nxt = ST_RUN;
      end
   end

   always_comb begin
      init_busy = (state == ST_INIT);
      clear_we  = (state == ST_INIT);
      accept    = (state == ST_RUN) && en;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)        ptr <= '0;
      else if (clear_we) ptr <= ptr + 1'b1;
   end

   // The array has no reset; a low rst_n simply blocks every write.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clear_we)           mem[ptr[ADDR_W-1:0]] <= '0;
         else if (accept && we)  mem[addr] <= din;
      end
   end

   generate
      if (WR_MODE == 1) begin : g_read_first
         assign wr_dout  = mem[addr];
         assign wr_valid = 1'b1;
      end else if (WR_MODE == 2) begin : g_write_first
         assign wr_dout  = din;
         assign wr_valid = 1'b1;
      end else begin : g_no_change
         assign wr_dout  = dout;
         assign wr_valid = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (accept) begin
         if (we) begin
            dout       <= wr_dout;
            dout_valid <= wr_valid;
         end else begin
            dout       <= mem[addr];
            dout_valid <= 1'b1;
         end
      end else begin
         dout_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_sp_param.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_param : three sram_sp_param instances (modes 0/1/2, 32x4 and 256x16)
// driven by shared stimulus and checked against an array-based reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_sp_param;

`ifdef SRAM_SP_PARAM_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, en, we;
   logic [7:0]  addr;
   logic [15:0] din;
   logic [3:0]  dout0, dout1;
   logic [15:0] dout2;
   logic [2:0]  val, busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sram_sp_param #(.DATA_W(4), .ADDR_W(5), .WR_MODE(0)) u_m0 (
      .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr[4:0]), .din(din[3:0]),
      .dout(dout0), .dout_valid(val[0]), .init_busy(busy[0]));
   sram_sp_param #(.DATA_W(4), .ADDR_W(5), .WR_MODE(1)) u_m1 (
      .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr[4:0]), .din(din[3:0]),
      .dout(dout1), .dout_valid(val[1]), .init_busy(busy[1]));
   sram_sp_param #(.DATA_W(16), .ADDR_W(8), .WR_MODE(2)) u_m2 (
      .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
      .dout(dout2), .dout_valid(val[2]), .init_busy(busy[2]));

   logic [15:0] got_dout [3];
   assign got_dout[0] = {12'h000, dout0};
   assign got_dout[1] = {12'h000, dout1};
   assign got_dout[2] = dout2;

   // Reference model: words, which words hold a defined value, and expected outputs.
   int          depth [3] = '{32, 32, 256};
   int          mode  [3] = '{0, 1, 2};
   logic [15:0] mask  [3] = '{16'h000F, 16'h000F, 16'hFFFF};
   logic [15:0] m_mem   [3][256];
   bit          m_known [3][256];
   logic [15:0] m_dout  [3];
   bit          m_dknown[3];
   bit          m_valid [3];
   int          m_init_left [3];
   bit          started = 1'b0;
   int          ma;
   logic [15:0] md, mold;
   bit          mold_known;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) started = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_init_left[i] = INIT_EN ? depth[i] : 0;
            m_dout[i]      = 16'h0;
            m_dknown[i]    = 1'b1;
            m_valid[i]     = 1'b0;
         end else if (m_init_left[i] > 0) begin
            m_mem[i][depth[i] - m_init_left[i]]   = 16'h0;
            m_known[i][depth[i] - m_init_left[i]] = 1'b1;
            m_init_left[i]--;
            m_valid[i] = 1'b0;
         end else if (en) begin
            ma = int'(addr) % depth[i];
            md = din & mask[i];
            if (!we) begin
               m_dout[i]   = m_mem[i][ma];
               m_dknown[i] = m_known[i][ma];
               m_valid[i]  = 1'b1;
            end else begin
               mold       = m_mem[i][ma];
               mold_known = m_known[i][ma];
               m_mem[i][ma]   = md;
               m_known[i][ma] = 1'b1;
               if (mode[i] == 1) begin
                  m_dout[i] = mold; m_dknown[i] = mold_known; m_valid[i] = 1'b1;
               end else if (mode[i] == 2) begin
                  m_dout[i] = md; m_dknown[i] = 1'b1; m_valid[i] = 1'b1;
               end else begin
                  m_valid[i] = 1'b0;
               end
            end
         end else begin
            m_valid[i] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("dout_valid[%0d]", i), {15'h0, val[i]}, {15'h0, m_valid[i]});
            chk($sformatf("init_busy[%0d]", i), {15'h0, busy[i]}, {15'h0, m_init_left[i] > 0});
            if (m_dknown[i])
               chk($sformatf("dout[%0d]", i), got_dout[i], m_dout[i]);
         end
      end
   end

   task automatic step(input logic e, input logic w, input logic [7:0] a, input logic [15:0] d);
      en = e; we = w; addr = a; din = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy != 3'b000 && n < 400) begin
         step(1'b0, 1'b0, 8'h00, 16'h0000);
         n++;
      end
      if (busy != 3'b000) chk("init_timeout", {13'h0, busy}, 16'h0000);
   endtask

   int run;

   initial begin
      rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; din = '0;
      @(negedge clk);
      repeat (3) step(1'b1, 1'b1, 8'h07, 16'hFFFF);
      chk("reset_dout0", got_dout[0], 16'h0000);
      chk("reset_valid", {13'h0, val}, 16'h0000);
      rst_n = 1'b1;
      // Access attempts during the sweep must be ignored.
      repeat (4) step(1'b1, 1'b1, 8'h07, 16'h000F);
      wait_idle();

      step(1'b1, 1'b1, 8'h05, 16'h000A);
      chk("m0_write_no_valid", {15'h0, val[0]}, 16'h0000);
      step(1'b1, 1'b0, 8'h05, 16'h0000);
      chk("m0_read_back", got_dout[0], 16'h000A);
      chk("m0_read_valid", {15'h0, val[0]}, 16'h0001);

      step(1'b1, 1'b1, 8'h03, 16'h0006);
      step(1'b1, 1'b1, 8'h03, 16'h0009);
      chk("m1_read_first", got_dout[1], 16'h0006);
      chk("m2_write_first", got_dout[2], 16'h0009);
      chk("m12_write_valid", {14'h0, val[2:1]}, 16'h0003);

      for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), 16'(i) ^ 16'hA5A5);
      run = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 1'b0, 8'(i), 16'h0000);
         if (val[2]) run++;
         if (i == 8'h3C) chk("m2_sweep_word3c", got_dout[2], 16'hA599);
      end
      chk("m2_sweep_valid_run", 16'(run), 16'd256);

      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 255)), 16'($urandom));
      end
      rst_n = 1'b1;
      wait_idle();

      step(1'b1, 1'b1, 8'h05, 16'h000C);
      step(1'b1, 1'b0, 8'h05, 16'h0000);
      chk("pre_reset_read", got_dout[0], 16'h000C);
      rst_n = 1'b0;
      step(1'b1, 1'b0, 8'h05, 16'h0000);
      chk("mid_run_reset_dout", got_dout[0], 16'h0000);
      chk("mid_run_reset_valid", {13'h0, val}, 16'h0000);
      rst_n = 1'b1;
      wait_idle();
      step(1'b1, 1'b0, 8'h05, 16'h0000);
      step(1'b0, 1'b0, 8'h00, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
